// File: rtl/sync_debounce_multi_pkg.sv
// Shared constants and helpers for the multi-channel synchronizer/debouncer.
// Imported by the channel filter and the top level.
package sync_debounce_multi_pkg;

    // Filter counter width; a one-sample filter still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned len);
        return (len <= 1) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/sync_debounce_multi_if.sv
// Status-line bundle: async inputs and clear strobes in, debounced levels and events out.
interface sync_debounce_multi_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] sig_in;
    logic [WIDTH-1:0] sticky_clr;
    logic [WIDTH-1:0] sig_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] sticky;

    modport master (
        output sig_in, sticky_clr,
        input  sig_out, rise, fall, sticky
    );

    modport slave (
        input  sig_in, sticky_clr,
        output sig_out, rise, fall, sticky
    );
endinterface

// File: rtl/sync_debounce_chan.sv
// One-bit stable-count debounce with registered rise/fall strobes and a sticky change flag.
module sync_debounce_chan
    import sync_debounce_multi_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter bit          INIT_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic sticky_clr,
    output logic sig_out,
    output logic rise,
    output logic fall,
    output logic sticky
);
    localparam int unsigned     CNT_W   = cnt_width(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             update;

    always_comb begin
        differ = s ^ sig_out;
        update = differ && (cnt == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_out <= INIT_VAL;
            cnt     <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            sticky  <= 1'b0;
        end else begin
            rise <= update & s;
            fall <= update & ~s;
            if (update)      cnt <= '0;
            else if (differ) cnt <= cnt + 1'b1;
            else             cnt <= '0;
            if (update) sig_out <= s;
            // An event in the same cycle as a clear must not be lost.
            if (update)          sticky <= 1'b1;
            else if (sticky_clr) sticky <= 1'b0;
        end
    end
endmodule

// File: rtl/synchronizer.sv
// Multi-stage flop synchronizer for asynchronous level inputs.
// Synchronous active-high reset loads INIT_VAL into every stage.
module synchronizer #(
    parameter int unsigned          WIDTH            = 1,
    parameter int unsigned          STAGES           = 2,
    parameter logic [WIDTH-1:0]     INIT_VAL         = '0,
    parameter bit                   FALSE_PATH_TO_IN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] chain [STAGES-1];

    // The capture flop sits in a distinctly named block so timing constraints can anchor on it.
    if (FALSE_PATH_TO_IN) begin : g_fp_in
        always_ff @(posedge clk) begin
            if (rst) meta <= INIT_VAL;
            else     meta <= d;
        end
    end else begin : g_in
        always_ff @(posedge clk) begin
            if (rst) meta <= INIT_VAL;
            else     meta <= d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES - 1; i++) chain[i] <= INIT_VAL;
        end else begin
            chain[0] <= meta;
            for (int unsigned i = 1; i < STAGES - 1; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-2];
endmodule

// File: rtl/sync_debounce_multi.sv
// WIDTH independent async status lines: synchronize, debounce, and flag edges per channel.
// Channels are not coherent with each other.
module sync_debounce_multi
    import sync_debounce_multi_pkg::*;
#(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      STAGES      = 2,
    parameter logic [WIDTH-1:0] INITIAL_VAL = '0,
    parameter int unsigned      FILTER_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sync_debounce_multi_if.slave  bus
);
    logic             rst;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] sig_out_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] sticky_w;

    assign rst = ~rst_n;

    synchronizer #(
        .WIDTH            (WIDTH),
        .STAGES           (STAGES),
        .INIT_VAL         (INITIAL_VAL),
        .FALSE_PATH_TO_IN (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.sig_in),
        .q   (s)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_debounce_chan #(
            .FILTER_LEN (FILTER_LEN),
            .INIT_VAL   (INITIAL_VAL[i])
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .s          (s[i]),
            .sticky_clr (bus.sticky_clr[i]),
            .sig_out    (sig_out_w[i]),
            .rise       (rise_w[i]),
            .fall       (fall_w[i]),
            .sticky     (sticky_w[i])
        );
    end

    assign bus.sig_out = sig_out_w;
    assign bus.rise    = rise_w;
    assign bus.fall    = fall_w;
    assign bus.sticky  = sticky_w;
endmodule
